dm_cache_fsm: RTL

DM_CACHE_FSM -- requirements
Module: dm_cache_fsm

---
 rtl/cache_def.sv | 51 +++++
 rtl/dm_cache_fsm.sv | 112 +++++++++++
 2 files changed

// File: rtl/cache_def.sv
// Shared types and address-split constants for the direct-mapped cache controller.
package cache_def;

   localparam int TAGMSB = 31;
   localparam int TAGLSB = 14;

   typedef struct packed {
      logic                   valid;
      logic                   dirty;
      logic [TAGMSB-TAGLSB:0] tag;
   } cache_tag_type;

   typedef struct packed {
      logic [9:0] index;
      logic       we;
   } cache_req_type;

   typedef logic [127:0] cache_data_type;

   typedef struct packed {
      logic [31:0]  addr;
      logic [127:0] data;
      logic         rw;
      logic         valid;
   } mem_req_type;

   typedef struct packed {
      cache_data_type data;
      logic           ready;
   } mem_data_type;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        rw;
      logic        valid;
   } cpu_req_type;

   typedef struct packed {
      logic [31:0] data;
      logic        ready;
   } cpu_result_type;

   typedef enum logic [1:0] {
      IDLE,
      COMPARE_TAG,
      ALLOCATE,
      WRITE_BACK
   } cache_state_type;

endpackage

// File: rtl/dm_cache_fsm.sv
// Direct-mapped, write-back, write-allocate cache controller.
// state       | meaning
// IDLE        | waiting for a CPU request; array index follows cpu_req.addr
// COMPARE_TAG | tag compare on the latched request; hit completes, miss goes to memory
// ALLOCATE    | line fill outstanding on mem_req; writes the line when memory is ready
// WRITE_BACK  | dirty victim being written to memory before the fill
module dm_cache_fsm
   import cache_def::*;
(
   input  logic           clk,
   input  logic           rst,
   input  cpu_req_type    cpu_req,
   output cpu_result_type cpu_res,
   output mem_req_type    mem_req,
   input  mem_data_type   mem_data,
   output cache_req_type  tag_req,
   output cache_req_type  data_req,
   output cache_tag_type  tag_write,
   input  cache_tag_type  tag_read,
   output cache_data_type data_write,
   input  cache_data_type data_read
);

   cache_state_type state_q, state_d;
   cpu_req_type     req_q, req_d;
   mem_req_type     mem_req_q, mem_req_d;

   logic [9:0]             index;
   logic [TAGMSB-TAGLSB:0] req_tag;
   logic [6:0]             word_lsb;
   logic                   hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         req_q     <= '0;
         mem_req_q <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         mem_req_q <= mem_req_d;
      end
   end

   assign mem_req  = mem_req_q;
   assign req_tag  = req_q.addr[TAGMSB:TAGLSB];
   assign word_lsb = {req_q.addr[3:2], 5'b0};
   assign index    = (state_q == IDLE) ? cpu_req.addr[13:4] : req_q.addr[13:4];
   assign hit      = tag_read.valid && (tag_read.tag == req_tag);

   always_comb begin
      state_d        = state_q;
      req_d          = req_q;
      mem_req_d      = mem_req_q;
      cpu_res        = '0;
      tag_req.index  = index;
      tag_req.we     = 1'b0;
      data_req.index = index;
      data_req.we    = 1'b0;
      tag_write      = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
      data_write     = data_read;

      unique case (state_q)
         IDLE: begin
            if (cpu_req.valid) begin
               req_d   = cpu_req;
               state_d = COMPARE_TAG;
            end
         end
         COMPARE_TAG: begin
            if (hit) begin
               cpu_res.ready = 1'b1;
               cpu_res.data  = data_read[word_lsb +: 32];
               if (req_q.rw) begin
                  tag_req.we                  = 1'b1;
                  data_req.we                 = 1'b1;
                  tag_write.dirty             = 1'b1;
                  data_write[word_lsb +: 32]  = req_q.data;
               end
               state_d = IDLE;
            end else if (tag_read.valid && tag_read.dirty) begin
               mem_req_d = '{addr: {tag_read.tag, req_q.addr[13:4], 4'b0},
                             data: data_read, rw: 1'b1, valid: 1'b1};
               state_d   = WRITE_BACK;
            end else begin
               mem_req_d = '{addr: {req_q.addr[31:4], 4'b0},
                             data: '0, rw: 1'b0, valid: 1'b1};
               state_d   = ALLOCATE;
            end
         end
         WRITE_BACK: begin
            // Victim accepted: switch straight to the fill without dropping valid.
            if (mem_data.ready) begin
               mem_req_d = '{addr: {req_q.addr[31:4], 4'b0},
                             data: '0, rw: 1'b0, valid: 1'b1};
               state_d   = ALLOCATE;
            end
         end
         ALLOCATE: begin
            if (mem_data.ready) begin
               tag_req.we      = 1'b1;
               data_req.we     = 1'b1;
               data_write      = mem_data.data;
               mem_req_d.valid = 1'b0;
               state_d         = COMPARE_TAG;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
